ex_mem_skid_stage: RTL and testbench

Parametrised EX→MEM pipeline stage with a two-entry skid buffer and valid/ready handshake on both sides. It replaces the free-running EX/MEM register, adding back-pressure, bubble insertion and flush. It carries a control bundle (regWrite, memWrite, lui, resultSrc) and a data bundle (ALUResult, writeData, PCPlus4, extImm, Rd) without reordering. It also reports occupancy and a saturating back-pressure cycle count for performance debug.

---
 rtl/ex_mem_skid_stage.sv | 86 ++++++++
 tb/tb_ex_mem_skid_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with a two-entry skid buffer, flush and bubble masking.
// One-cycle latency. in_ready is a registered signal (!skid_v), so there is no path from out_ready to in_ready.
module ex_mem_skid_stage #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v;
  logic              skid_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              acc;
  logic              pop;

  assign in_ready  = !skid_v;
  assign acc       = in_valid & in_ready;
  assign pop       = main_v & out_ready;
  assign out_valid = main_v;
  // A bubble must never carry regWrite/memWrite downstream.
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // Data registers are left alone; only valids and control are killed.
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (!main_v || pop) begin
      if (skid_v) begin
        // skid full implies in_ready=0, so no new beat arrives this edge.
        main_v    <= 1'b1;
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_v    <= 1'b0;
      end else begin
        main_v <= acc;
        if (acc) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end
      end
    end else if (acc) begin
      skid_v    <= 1'b1;
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: per-cycle vector table with a beat scoreboard, then reset and saturation sequences.
module tb_ex_mem_skid_stage;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 133;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  logic              in_ready4, out_valid4;
  logic [CTRL_W-1:0] out_ctrl4;
  logic [DATA_W-1:0] out_data4;
  logic [1:0]        occupancy4;
  logic [3:0]        stall_cnt4;

  ex_mem_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_mem_skid_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
    .out_data(out_data4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [4:0]  ctrl;
    bit          erdy;
    bit          eov;
    logic [1:0]  eocc;
    logic [15:0] estall;
    bit          chk_hold;
  } row_t;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  row_t  tbl[29];
  beat_t sb[$];
  beat_t popped;
  int    n_checks = 0;
  int    n_pass   = 0;
  int unsigned beat_id = 1;
  logic [DATA_W-1:0] hold_data = '0;
  logic [DATA_W-1:0] l_data;

  function automatic logic [DATA_W-1:0] make_data(int unsigned id);
    logic [31:0] v;
    v = id;
    return {v, v * 32'd3 + 32'd1, v + 32'h100, v ^ 32'hA5A5_0000, v[4:0]};
  endfunction

  function automatic row_t mk(bit iv, bit ordy, bit fl, logic [4:0] ctrl, bit erdy,
                              bit eov, logic [1:0] eocc, logic [15:0] estall, bit chk_hold);
    row_t r;
    r.iv = iv; r.ordy = ordy; r.fl = fl; r.ctrl = ctrl; r.erdy = erdy;
    r.eov = eov; r.eocc = eocc; r.estall = estall; r.chk_hold = chk_hold;
    return r;
  endfunction

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  initial begin
    // stream 8 beats with out_ready=1
    tbl[0] = mk(1, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd0, 0);
    for (int i = 1; i < 8; i++) tbl[i] = mk(1, 1, 0, 5'b10001, 1, 1, 2'd1, 16'd0, 0);
    tbl[8]  = mk(0, 1, 0, 5'b10001, 1, 1, 2'd1, 16'd0, 0);
    tbl[9]  = mk(0, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd0, 1);
    // back-pressure A,B,C,D
    tbl[10] = mk(1, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd0, 0);
    tbl[11] = mk(1, 0, 0, 5'b10001, 1, 1, 2'd1, 16'd0, 0);
    tbl[12] = mk(1, 0, 0, 5'b10001, 0, 1, 2'd2, 16'd1, 0);
    tbl[13] = mk(1, 0, 0, 5'b10001, 0, 1, 2'd2, 16'd2, 0);
    tbl[14] = mk(1, 1, 0, 5'b10001, 0, 1, 2'd2, 16'd3, 0);
    tbl[15] = mk(1, 1, 0, 5'b10001, 1, 1, 2'd1, 16'd3, 0);
    tbl[16] = mk(1, 1, 0, 5'b10001, 1, 1, 2'd1, 16'd3, 0);
    tbl[17] = mk(0, 1, 0, 5'b10001, 1, 1, 2'd1, 16'd3, 0);
    tbl[18] = mk(0, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd3, 1);
    // flush while full, then flush of a just-accepted beat
    tbl[19] = mk(1, 0, 0, 5'b10001, 1, 0, 2'd0, 16'd3, 0);
    tbl[20] = mk(1, 0, 0, 5'b10001, 1, 1, 2'd1, 16'd3, 0);
    tbl[21] = mk(1, 0, 1, 5'b10001, 0, 1, 2'd2, 16'd4, 0);
    tbl[22] = mk(0, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd5, 0);
    tbl[23] = mk(1, 0, 1, 5'b11111, 1, 0, 2'd0, 16'd5, 0);
    tbl[24] = mk(0, 1, 0, 5'b10001, 1, 0, 2'd0, 16'd5, 0);
    // bubble after a store/write beat
    tbl[25] = mk(1, 1, 0, 5'b11000, 1, 0, 2'd0, 16'd5, 0);
    tbl[26] = mk(0, 1, 0, 5'b11000, 1, 1, 2'd1, 16'd5, 0);
    tbl[27] = mk(0, 1, 0, 5'b11000, 1, 0, 2'd0, 16'd5, 1);
    tbl[28] = mk(0, 1, 0, 5'b11000, 1, 0, 2'd0, 16'd5, 1);

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    #2 rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_ctrl   = tbl[i].ctrl;
      in_data   = make_data(beat_id);
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      check($sformatf("row%0d_in_ready", i), in_ready, tbl[i].erdy);
      check($sformatf("row%0d_out_valid", i), out_valid, tbl[i].eov);
      check($sformatf("row%0d_occupancy", i), occupancy, tbl[i].eocc);
      check($sformatf("row%0d_stall_cnt", i), stall_cnt, tbl[i].estall);
      if (tbl[i].eov) begin
        if (sb.size() == 0) begin
          check($sformatf("row%0d_sb_nonempty", i), 0, 1);
        end else begin
          check($sformatf("row%0d_out_ctrl", i), out_ctrl, sb[0].ctrl);
          check($sformatf("row%0d_out_data", i), out_data, sb[0].data);
          if (tbl[i].ordy && !tbl[i].fl) begin
            popped    = sb.pop_front();
            hold_data = popped.data;
          end
        end
      end else begin
        check($sformatf("row%0d_bubble_ctrl", i), out_ctrl, 0);
        if (tbl[i].chk_hold) check($sformatf("row%0d_hold_data", i), out_data, hold_data);
      end
      if (tbl[i].fl) sb.delete();
      else if (tbl[i].iv && tbl[i].erdy) sb.push_back('{tbl[i].ctrl, make_data(beat_id)});
      if (tbl[i].iv && tbl[i].erdy) beat_id++;
    end
    @(negedge clk);
    check("tail_sb_drained", sb.size(), 0);

    // reset mid-stream with two beats held
    in_valid = 1'b1; in_ctrl = 5'b10001; in_data = make_data(100); out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("pre_rst_occ1", occupancy, 1);
    in_data = make_data(101);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_occ2", occupancy, 2);
    check("pre_rst_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_ctrl", out_ctrl, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_occupancy", occupancy, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    check("mid_rst_stall_cnt4", stall_cnt4, 0);
    check("mid_rst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    l_data = make_data(102);
    in_valid = 1'b1; in_ctrl = 5'b10001; in_data = l_data; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_out_data", out_data, l_data);
    check("post_rst_out_ctrl", out_ctrl, 5'b10001);
    check("post_rst_occupancy", occupancy, 1);

    // held beat with out_ready low: 16-bit counter keeps going, 4-bit one stops at 15
    check("sat_n0_cnt16", stall_cnt, 0);
    check("sat_n0_cnt4", stall_cnt4, 0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check($sformatf("sat_n%0d_cnt16", n), stall_cnt, n);
      check($sformatf("sat_n%0d_cnt4", n), stall_cnt4, (n > 15) ? 15 : n);
    end
    check("sat_out_valid", out_valid4, 1);
    check("sat_in_ready", in_ready4, 1);
    check("sat_out_data", out_data4, l_data);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
